// File: rtl/frame_reader.sv
// Read-side sequencer for the STFT framing buffer: walks one window of samples per frame,
// rewinds by HOP_LENGTH, and streams tagged samples through a 2-entry skid FIFO.
module frame_reader #(
  parameter int WIDTH      = 32,
  parameter int WIN_LENGTH = 480,
  parameter int HOP_LENGTH = 160,
  parameter int IDX_WIDTH  = $clog2(WIN_LENGTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  output logic                 buf_rd_en,
  output logic                 buf_rd_jump,
  output logic                 buf_frm_init,
  input  logic [WIDTH-1:0]     buf_dout,
  input  logic                 buf_empty,
  input  logic                 buf_almost_empty,
  output logic [WIDTH-1:0]     m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_sof,
  output logic                 m_eof,
  output logic [IDX_WIDTH-1:0] m_idx,
  output logic                 frame_done,
  output logic [15:0]          frame_cnt,
  output logic                 busy
);

  if (WIN_LENGTH < 2 || HOP_LENGTH < 1 || HOP_LENGTH > WIN_LENGTH) begin : g_bad_params
    $error("frame_reader: WIN_LENGTH must be >= 2 and HOP_LENGTH in 1..WIN_LENGTH");
  end

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(WIN_LENGTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, END_FRAME} state_t;

  state_t               state, state_next;
  logic [IDX_WIDTH-1:0] rd_idx, rd_idx_next;
  logic                 inflight;
  logic [IDX_WIDTH-1:0] inflight_idx;

  logic [WIDTH-1:0]     fifo_data [2];
  logic [IDX_WIDTH-1:0] fifo_idx  [2];
  logic                 wr_ptr, rd_ptr;
  logic [1:0]           fifo_cnt;

  logic push, pop, start, issue;

  assign push  = inflight;
  assign pop   = m_valid & m_ready;
  assign start = enable & ~buf_almost_empty & ~buf_empty;
  // Reserve a FIFO slot for every read still in flight so backpressure never overflows it.
  assign issue = (state == RUN) & ~buf_empty &
                 (({1'b0, fifo_cnt} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rd_idx <= '0;
    end else begin
      state  <= state_next;
      rd_idx <= rd_idx_next;
    end
  end

  always_comb begin
    state_next   = state;
    rd_idx_next  = rd_idx;
    buf_rd_en    = 1'b0;
    buf_rd_jump  = 1'b0;
    buf_frm_init = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next  = RUN;
          rd_idx_next = '0;
        end
      end
      RUN: begin
        if (issue) begin
          buf_rd_en    = 1'b1;
          buf_frm_init = (rd_idx == '0);
          buf_rd_jump  = (rd_idx == LAST_IDX);
          if (rd_idx == LAST_IDX) begin
            state_next  = END_FRAME;
            rd_idx_next = '0;
          end else begin
            rd_idx_next = rd_idx + IDX_WIDTH'(1);
          end
        end
      end
      END_FRAME: state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Read data lands one cycle after issue and is tagged with the index it was read under.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight     <= 1'b0;
      inflight_idx <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      fifo_cnt     <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_idx[i]  <= '0;
      end
    end else begin
      inflight     <= buf_rd_en;
      inflight_idx <= rd_idx;
      if (push) begin
        fifo_data[wr_ptr] <= buf_dout;
        fifo_idx[wr_ptr]  <= inflight_idx;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done <= 1'b0;
      frame_cnt  <= 16'd0;
    end else begin
      frame_done <= pop & m_eof;
      if (pop & m_eof) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign m_valid = (fifo_cnt != 2'd0);
  assign m_data  = fifo_data[rd_ptr];
  assign m_idx   = fifo_idx[rd_ptr];
  assign m_sof   = m_valid & (m_idx == '0);
  assign m_eof   = m_valid & (m_idx == LAST_IDX);
  assign busy    = (state != IDLE) | (fifo_cnt != 2'd0);

endmodule

// File: tb/tb_frame_reader.sv
// Directed bench for frame_reader with WIN_LENGTH=8, HOP_LENGTH=4 against a behavioural
// circular-buffer model holding samples 0..31 (data value 0xA000 + sample number).
module tb_frame_reader;

  localparam int WIDTH = 32;
  localparam int WIN   = 8;
  localparam int HOP   = 4;
  localparam int IDXW  = 3;
  localparam int NSAMP = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic             buf_rd_en, buf_rd_jump, buf_frm_init;
  logic [WIDTH-1:0] buf_dout;
  logic             buf_empty, buf_almost_empty;
  logic [WIDTH-1:0] m_data;
  logic             m_valid, m_ready, m_sof, m_eof;
  logic [IDXW-1:0]  m_idx;
  logic             frame_done;
  logic [15:0]      frame_cnt;
  logic             busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  frame_reader #(.WIDTH(WIDTH), .WIN_LENGTH(WIN), .HOP_LENGTH(HOP), .IDX_WIDTH(IDXW)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .buf_rd_en(buf_rd_en), .buf_rd_jump(buf_rd_jump), .buf_frm_init(buf_frm_init),
    .buf_dout(buf_dout), .buf_empty(buf_empty), .buf_almost_empty(buf_almost_empty),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_sof(m_sof), .m_eof(m_eof), .m_idx(m_idx),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .busy(busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Buffer model: read pointer, latched frame start, rewind to start+HOP on the jump read.
  int   bm_ptr = 0;
  int   bm_start = 0;
  logic force_empty = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      bm_ptr   <= 0;
      bm_start <= 0;
      buf_dout <= '0;
    end else if (buf_rd_en) begin
      buf_dout <= 32'hA000 + 32'(bm_ptr);
      if (buf_frm_init) bm_start <= bm_ptr;
      if (buf_rd_jump) bm_ptr <= (buf_frm_init ? bm_ptr : bm_start) + HOP;
      else             bm_ptr <= bm_ptr + 1;
    end
  end

  assign buf_empty        = force_empty | (bm_ptr >= NSAMP);
  assign buf_almost_empty = (NSAMP - bm_ptr) < WIN;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic bp_mode = 1'b0;
  int   bp_phase = 0;
  initial forever begin
    @(posedge clk);
    #1;
    if (bp_mode) begin
      m_ready  = (bp_phase == 0);
      bp_phase = (bp_phase + 1) % 3;
    end
  end

  // Stream monitor with its own FIFO-occupancy and frame models.
  int          occ = 0, inflight_m = 0, rd_in_frame = 0, total_reads = 0, frames_started = 0;
  int          exp_frame = 0, exp_idx = 0, cnt_model = 0, accepted = 0, last_jump = -1;
  logic        done_exp = 1'b0, prev_stall = 1'b0, gap_check = 1'b0;
  logic [31:0] held_data;
  logic [IDXW-1:0] held_idx;

  always @(negedge clk) begin
    logic mpop;
    if (rst) begin
      occ = 0; inflight_m = 0; rd_in_frame = 0; exp_frame = 0; exp_idx = 0;
      cnt_model = 0; accepted = 0; last_jump = -1; frames_started = 0;
      done_exp = 1'b0; prev_stall = 1'b0;
    end else begin
      mpop = m_valid & m_ready;
      checkOutput("valid_vs_occ", 32'(m_valid), 32'(occ != 0));
      checkOutput("frame_done", 32'(frame_done), 32'(done_exp));
      checkOutput("frame_cnt", 32'(frame_cnt), 32'(cnt_model[15:0]));
      if (prev_stall) begin
        checkOutput("hold_data", m_data, held_data);
        checkOutput("hold_idx", 32'(m_idx), 32'(held_idx));
      end
      if (buf_rd_en) begin
        checkOutput("issue_gate", 32'((occ + inflight_m - int'(mpop)) < 2), 1);
        checkOutput("rd_while_empty", 32'(buf_empty), 0);
        checkOutput("frm_init", 32'(buf_frm_init), 32'(rd_in_frame == 0));
        checkOutput("rd_jump", 32'(buf_rd_jump), 32'(rd_in_frame == WIN - 1));
        if (buf_frm_init) begin
          frames_started++;
          if (gap_check && last_jump >= 0) checkOutput("frame_gap", 32'(cyc - last_jump), 3);
        end
        if (rd_in_frame == WIN - 1) begin
          last_jump   = cyc;
          rd_in_frame = 0;
        end else begin
          rd_in_frame++;
        end
        total_reads++;
      end else begin
        checkOutput("stray_strobe", 32'(buf_rd_jump | buf_frm_init), 0);
      end
      done_exp = 1'b0;
      if (mpop) begin
        checkOutput("data", m_data, 32'hA000 + 32'(exp_frame * HOP + exp_idx));
        checkOutput("sof", 32'(m_sof), 32'(exp_idx == 0));
        checkOutput("eof", 32'(m_eof), 32'(exp_idx == WIN - 1));
        checkOutput("idx", 32'(m_idx), 32'(exp_idx));
        accepted++;
        if (exp_idx == WIN - 1) begin
          exp_idx = 0;
          exp_frame++;
          cnt_model++;
          done_exp = 1'b1;
        end else begin
          exp_idx++;
        end
      end
      prev_stall = m_valid & ~m_ready;
      held_data  = m_data;
      held_idx   = m_idx;
      occ        = occ + inflight_m - int'(mpop);
      inflight_m = int'(buf_rd_en);
      checkOutput("occ_bound", 32'(occ <= 2), 1);
    end
  end

  task automatic applyStimulus(input logic en_val);
    rst = 1'b1;
    enable = 1'b0;
    force_empty = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    enable = en_val;
  endtask

  task automatic waitIdle(input int budget);
    logic found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (!busy) found = 1'b1;
    end
    checkOutput("idle_wait", 32'(found), 1);
  endtask

  task automatic waitInFrame(input int n, input int budget);
    logic found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      #1;
      if (rd_in_frame == n) found = 1'b1;
    end
    checkOutput("read_wait", 32'(found), 1);
  endtask

  task automatic waitStarts(input int n, input int budget);
    logic found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      #1;
      if (frames_started >= n) found = 1'b1;
    end
    checkOutput("start_wait", 32'(found), 1);
  endtask

  initial begin
    int reads_before;
    rst = 1'b1;
    enable = 1'b0;
    m_ready = 1'b1;

    // Reset values after three reset cycles
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checkOutput("rst_rd_en", 32'(buf_rd_en), 0);
    checkOutput("rst_jump", 32'(buf_rd_jump), 0);
    checkOutput("rst_init", 32'(buf_frm_init), 0);
    checkOutput("rst_valid", 32'(m_valid), 0);
    checkOutput("rst_sof", 32'(m_sof), 0);
    checkOutput("rst_eof", 32'(m_eof), 0);
    checkOutput("rst_done", 32'(frame_done), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_idx", 32'(m_idx), 0);
    checkOutput("rst_data", m_data, 0);
    checkOutput("rst_cnt", 32'(frame_cnt), 0);

    // Single frame and start latency
    applyStimulus(1'b1);
    @(negedge clk);
    checkOutput("lat_c0_rd", 32'(buf_rd_en), 0);
    @(negedge clk);
    checkOutput("lat_c1_rd", 32'(buf_rd_en), 1);
    checkOutput("lat_c1_init", 32'(buf_frm_init), 1);
    @(posedge clk);
    #1;
    enable = 1'b0;
    @(negedge clk);
    checkOutput("lat_c2_valid", 32'(m_valid), 0);
    @(negedge clk);
    checkOutput("lat_c3_valid", 32'(m_valid), 1);
    checkOutput("lat_c3_sof", 32'(m_sof), 1);
    checkOutput("lat_c3_idx", 32'(m_idx), 0);
    checkOutput("lat_c3_data", m_data, 32'hA000);
    waitIdle(100);
    checkOutput("single_cnt", 32'(frame_cnt), 1);
    checkOutput("single_accepted", 32'(accepted), 8);

    // Three overlapping frames, back to back
    applyStimulus(1'b1);
    gap_check = 1'b1;
    waitStarts(3, 200);
    enable = 1'b0;
    waitIdle(100);
    gap_check = 1'b0;
    checkOutput("overlap_cnt", 32'(frame_cnt), 3);
    checkOutput("overlap_accepted", 32'(accepted), 24);

    // Backpressure: ready one cycle in three
    applyStimulus(1'b1);
    bp_phase = 0;
    bp_mode = 1'b1;
    waitStarts(2, 300);
    enable = 1'b0;
    waitIdle(300);
    bp_mode = 1'b0;
    m_ready = 1'b1;
    checkOutput("bp_cnt", 32'(frame_cnt), 2);
    checkOutput("bp_accepted", 32'(accepted), 16);

    // Buffer empty for four cycles once rd_idx reaches 5
    applyStimulus(1'b1);
    waitInFrame(5, 100);
    @(posedge clk);
    #1;
    force_empty = 1'b1;
    enable = 1'b0;
    reads_before = total_reads;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    force_empty = 1'b0;
    checkOutput("stall_reads", 32'(total_reads - reads_before), 0);
    waitIdle(100);
    checkOutput("stall_cnt", 32'(frame_cnt), 1);
    checkOutput("stall_accepted", 32'(accepted), 8);

    // Enable dropped mid-frame: frame completes, no further starts
    applyStimulus(1'b1);
    waitInFrame(3, 100);
    @(posedge clk);
    #1;
    enable = 1'b0;
    waitIdle(100);
    reads_before = total_reads;
    repeat (20) @(negedge clk);
    checkOutput("en_drop_reads", 32'(total_reads - reads_before), 0);
    checkOutput("en_drop_busy", 32'(busy), 0);
    checkOutput("en_drop_cnt", 32'(frame_cnt), 1);

    // Reset mid-frame
    applyStimulus(1'b1);
    waitInFrame(3, 100);
    @(posedge clk);
    #1;
    rst = 1'b1;
    enable = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_rd_en", 32'(buf_rd_en), 0);
    checkOutput("mid_rst_valid", 32'(m_valid), 0);
    checkOutput("mid_rst_busy", 32'(busy), 0);
    checkOutput("mid_rst_idx", 32'(m_idx), 0);
    checkOutput("mid_rst_data", m_data, 0);
    checkOutput("mid_rst_cnt", 32'(frame_cnt), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("mid_rst_stale", 32'(m_valid), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "[TB] timeout");
  end

endmodule
